// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost thresholds and overflow/underflow pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; the default is registered read (latency 1).
module sync_fifo_param #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic                       rd_en,
  input  logic [WIDTH-1:0]           D_in,
  output logic [WIDTH-1:0]           D_out,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;
  logic             overflow_reg;
  logic             underflow_reg;
  logic             rd_ok;
  logic             wr_ok;

  assign empty        = (count_reg == '0);
  assign full         = (count_reg == CW'(DEPTH));
  assign almost_full  = (count_reg >= CW'(AFULL_THRESH));
  assign almost_empty = (count_reg <= CW'(AEMPTY_THRESH));
  assign count        = count_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a paired push.
  assign rd_ok = rd_en & ~empty;
  assign wr_ok = wr_en & (~full | rd_ok);

  always_comb begin
    count_next = count_reg;
    case ({wr_ok, rd_ok})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (rd_ok) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg     <= count_next;
      overflow_reg  <= wr_en & ~wr_ok;
      underflow_reg <= rd_en & ~rd_ok;
    end
  end

  // Storage carries no reset so it maps onto block/distributed RAM.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) mem[wr_ptr_reg] <= D_in;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign D_out = empty ? '0 : mem[rd_ptr_reg];
`else
  logic [WIDTH-1:0] dout_reg;

  always_ff @(posedge clk) begin
    if (rst)        dout_reg <= '0;
    else if (rd_ok) dout_reg <= mem[rd_ptr_reg];
  end

  assign D_out = dout_reg;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: directed scenarios plus biased random traffic,
// compared every cycle against a queue-based reference model.
module tb_sync_fifo_param;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 16;
  localparam int AFULL  = DEPTH - 2;
  localparam int AEMPTY = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] D_in;
  logic [WIDTH-1:0] D_out;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [$clog2(DEPTH):0] count;
  logic             overflow;
  logic             underflow;

  sync_fifo_param #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_THRESH(AFULL), .AEMPTY_THRESH(AEMPTY)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .D_in(D_in), .D_out(D_out),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [WIDTH-1:0] q [$];
  logic [WIDTH-1:0] m_dout;
  logic             m_ovf;
  logic             m_unf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  // One clock of stimulus; the model advances from the pre-edge queue, then all outputs are checked.
  task automatic step(input logic r, input logic w, input logic rd, input logic [WIDTH-1:0] d);
    bit rd_ok;
    bit wr_ok;
    rst = r; wr_en = w; rd_en = rd; D_in = d;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      rd_ok = rd && (q.size() != 0);
      wr_ok = w && ((q.size() < DEPTH) || rd_ok);
      m_ovf = w && !wr_ok;
      m_unf = rd && !rd_ok;
      if (rd_ok) m_dout = q.pop_front();
      if (wr_ok) q.push_back(d);
    end
`ifdef SYNC_FIFO_FWFT_EN
    m_dout = (q.size() != 0) ? q[0] : '0;
`endif
    #1;
    cyc++;
    $display("cyc %0d rst=%b wr=%b rd=%b din=%h | dout=%h cnt=%0d full=%b empty=%b af=%b ae=%b ovf=%b unf=%b",
             cyc, r, w, rd, d, D_out, count, full, empty, almost_full, almost_empty, overflow, underflow);
    check("count",        32'(count),        32'(q.size()));
    check("empty",        32'(empty),        32'(q.size() == 0));
    check("full",         32'(full),         32'(q.size() == DEPTH));
    check("almost_full",  32'(almost_full),  32'(q.size() >= AFULL));
    check("almost_empty", 32'(almost_empty), 32'(q.size() <= AEMPTY));
    check("overflow",     32'(overflow),     32'(m_ovf));
    check("underflow",    32'(underflow),    32'(m_unf));
    check("d_out",        32'(D_out),        32'(m_dout));
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; D_in = '0;
    m_dout = '0; m_ovf = 1'b0; m_unf = 1'b0;

    // Reset state
    step(1, 0, 0, 8'h00);
    check("reset_count", 32'(count), 32'd0);
    check("reset_dout",  32'(D_out), 32'd0);

    // Three pushes then three pops
    step(0, 1, 0, 8'h11);
    step(0, 1, 0, 8'h22);
    step(0, 1, 0, 8'h33);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 8'h00);
    step(0, 0, 0, 8'h00);

    // Fill, overflow attempt, drain
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 8'(i));
    step(0, 1, 0, 8'hAA);
    check("ovf_pulse", 32'(overflow), 32'd1);
    step(0, 0, 0, 8'h00);
    check("ovf_clears", 32'(overflow), 32'd0);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 8'h00);

    // Full with simultaneous push and pop
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 8'(i));
    step(0, 1, 1, 8'h55);
    check("full_both_count", 32'(count), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 8'h00);
    check("last_word_55", 32'(D_out), 32'h55);

    // Empty: lone pop, then push+pop together
    step(0, 0, 1, 8'h00);
    step(0, 1, 1, 8'h77);
    check("empty_both_count", 32'(count), 32'd1);
    step(0, 0, 1, 8'h00);

    // Threshold crossings and pointer wrap
    for (int i = 0; i < AFULL; i++) step(0, 1, 0, 8'($urandom));
    for (int i = 0; i < AFULL - AEMPTY; i++) step(0, 0, 1, 8'h00);
    for (int i = 0; i < 20; i++) step(0, 1, 1, 8'($urandom));
    while (q.size() != 0) step(0, 0, 1, 8'h00);

    // Reset mid-operation with a concurrent push
    for (int i = 0; i < 5; i++) step(0, 1, 0, 8'(8'hC0 + i));
    step(1, 1, 0, 8'hEE);
    step(0, 1, 0, 8'h99);
    step(0, 0, 1, 8'h00);
    step(0, 0, 0, 8'h00);

    // Biased random traffic: write-heavy, read-heavy and balanced phases
    for (int i = 0; i < 1500; i++) begin
      int phase;
      int pw;
      int pr;
      phase = (i / 100) % 3;
      pw = (phase == 0) ? 80 : (phase == 1) ? 25 : 50;
      pr = (phase == 0) ? 25 : (phase == 1) ? 80 : 50;
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 99) < pw),
           ($urandom_range(0, 99) < pr),
           8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
